// File: rtl/button_array.sv
// button_array: N-channel debounced push-button conditioner on the 1 kHz tick.
// Auto-repeat in the LONG state is compiled only with BUTTON_ARRAY_REPEAT_EN.
module button_array #(
   parameter int N         = 4,
   parameter int FILTER_MS = 50,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic         clk_1k,
   input  logic         rst_n,
   input  logic [N-1:0] button_pin,
   output logic [N-1:0] level_n,
   output logic [N-1:0] press_pulse,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] long_pulse,
   output logic [N-1:0] repeat_pulse
);

   typedef enum logic [1:0] {IDLE, DOWN, LONG} state_t;

   localparam logic [7:0]  FILT     = 8'(FILTER_MS);
   localparam logic [15:0] LONG_END = 16'(LONG_MS - 1);
`ifdef BUTTON_ARRAY_REPEAT_EN
   localparam logic [15:0] REP_END  = 16'(REPEAT_MS - 1);
`endif

   // Filter counter saturates at FILTER_MS so a long-stable pin keeps level_n refreshed.
   function automatic logic [7:0] filt_next(input logic [7:0] f);
      return (f < FILT) ? f + 8'd1 : f;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_ch
      logic        s;
      logic        lvl;
      logic        lvl_nx;
      logic        pressed;
      logic        released;
      logic        prs;
      logic        rel;
      logic        lng;
      logic [7:0]  f;
      logic [15:0] h;
      state_t      st;

      assign lvl_nx   = (button_pin[g] == s && f == FILT) ? s : lvl;
      assign pressed  = lvl & ~lvl_nx;
      assign released = ~lvl & lvl_nx;

`ifdef BUTTON_ARRAY_REPEAT_EN
      logic rep;
`endif

      always_ff @(posedge clk_1k or negedge rst_n) begin
         if (!rst_n) begin
            s   <= 1'b1;
            f   <= '0;
            lvl <= 1'b1;
            prs <= 1'b0;
            rel <= 1'b0;
            lng <= 1'b0;
            h   <= '0;
            st  <= IDLE;
`ifdef BUTTON_ARRAY_REPEAT_EN
            rep <= 1'b0;
`endif
         end else begin
            if (button_pin[g] != s) begin
               s <= button_pin[g];
               f <= '0;
            end else begin
               f <= filt_next(f);
            end
            lvl <= lvl_nx;
            prs <= pressed;
            rel <= released;
            lng <= 1'b0;
`ifdef BUTTON_ARRAY_REPEAT_EN
            rep <= 1'b0;
`endif
            // A release in the same cycle suppresses long/repeat pulses.
            case (st)
               IDLE: begin
                  if (pressed) begin
                     st <= DOWN;
                     h  <= '0;
                  end
               end
               DOWN: begin
                  if (released) begin
                     st <= IDLE;
                  end else if (h == LONG_END) begin
                     st  <= LONG;
                     lng <= 1'b1;
                     h   <= '0;
                  end else begin
                     h <= h + 16'd1;
                  end
               end
               LONG: begin
`ifdef BUTTON_ARRAY_REPEAT_EN
                  if (released) begin
                     st <= IDLE;
                  end else if (h == REP_END) begin
                     rep <= 1'b1;
                     h   <= '0;
                  end else begin
                     h <= h + 16'd1;
                  end
`else
                  if (released) begin
                     st <= IDLE;
                  end
`endif
               end
               default: st <= IDLE;
            endcase
         end
      end

      assign level_n[g]       = lvl;
      assign press_pulse[g]   = prs;
      assign release_pulse[g] = rel;
      assign long_pulse[g]    = lng;
`ifdef BUTTON_ARRAY_REPEAT_EN
      assign repeat_pulse[g]  = rep;
`else
      assign repeat_pulse[g]  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_array.sv
// Self-checking bench for button_array: per-cycle reference model, directed
// timing sequences, a phase table and randomized pin activity.
`timescale 1us/1ns
module tb_button_array;
   localparam int N   = 4;
   localparam int F   = 50;
   localparam int LMS = 1000;
   localparam int RMS = 200;

   logic         clk_1k = 1'b0;
   logic         rst_n  = 1'b0;
   logic [N-1:0] button_pin = '1;
   logic [N-1:0] level_n, press_pulse, release_pulse, long_pulse, repeat_pulse;

   button_array #(.N(N), .FILTER_MS(F), .LONG_MS(LMS), .REPEAT_MS(RMS)) dut (
      .clk_1k        (clk_1k),
      .rst_n         (rst_n),
      .button_pin    (button_pin),
      .level_n       (level_n),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   always #500 clk_1k = ~clk_1k;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: a level is accepted once F+2 consecutive samples agree;
   // hold time is measured in cycles since the accepted press.
   logic         m_run_val [N];
   int           m_run_len [N];
   int           m_hold    [N];
   logic [N-1:0] e_level, e_press, e_release, e_long, e_repeat;

   int cnt_press [N], cnt_release [N], cnt_long [N], cnt_repeat [N];
   int t_press [N], t_release [N], t_long [N];
   int rep_q [$];

   typedef struct {
      logic [N-1:0] pin;
      int           len;
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
      logic [N-1:0] lng;
   } vec_t;
   vec_t tbl [8];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_run_val[i] = 1'b1;
         m_run_len[i] = F + 2;
         m_hold[i]    = 0;
      end
      e_level = '1; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
   endtask

   task automatic model_step(input logic [N-1:0] pin);
      for (int i = 0; i < N; i++) begin
         logic nl;
         logic held;
         if (pin[i] == m_run_val[i]) m_run_len[i]++;
         else begin
            m_run_val[i] = pin[i];
            m_run_len[i] = 1;
         end
         nl = (m_run_len[i] >= F + 2) ? m_run_val[i] : e_level[i];
         e_press[i]   = e_level[i] & ~nl;
         e_release[i] = ~e_level[i] & nl;
         held = !e_level[i] && !nl;
         if (e_press[i]) m_hold[i] = 0;
         else if (held) m_hold[i]++;
         e_long[i] = held && (m_hold[i] == LMS);
`ifdef BUTTON_ARRAY_REPEAT_EN
         e_repeat[i] = held && (m_hold[i] > LMS) && ((m_hold[i] - LMS) % RMS == 0);
`else
         e_repeat[i] = 1'b0;
`endif
         e_level[i] = nl;
      end
   endtask

   task automatic check(input string name);
      n_checks++;
      if ({level_n, press_pulse, release_pulse, long_pulse, repeat_pulse} !==
          {e_level, e_press, e_release, e_long, e_repeat}) begin
         n_fail++;
         $display("FAIL %s cyc=%0d lvl/prs/rel/lng/rep got %b %b %b %b %b required %b %b %b %b %b",
                  name, cyc, level_n, press_pulse, release_pulse, long_pulse, repeat_pulse,
                  e_level, e_press, e_release, e_long, e_repeat);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic clear_log();
      for (int i = 0; i < N; i++) begin
         cnt_press[i] = 0; cnt_release[i] = 0; cnt_long[i] = 0; cnt_repeat[i] = 0;
         t_press[i] = -1; t_release[i] = -1; t_long[i] = -1;
      end
      rep_q.delete();
   endtask

   // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
   task automatic step(input logic [N-1:0] pin);
      button_pin = pin;
      @(posedge clk_1k);
      if (rst_n) model_step(pin);
      @(negedge clk_1k);
      check("cycle");
      for (int i = 0; i < N; i++) begin
         if (press_pulse[i])   begin cnt_press[i]++;   t_press[i]   = cyc; end
         if (release_pulse[i]) begin cnt_release[i]++; t_release[i] = cyc; end
         if (long_pulse[i])    begin cnt_long[i]++;    t_long[i]    = cyc; end
         if (repeat_pulse[i])  cnt_repeat[i]++;
      end
      if (repeat_pulse[2]) rep_q.push_back(cyc);
      cyc++;
   endtask

   task automatic do_reset(input logic [N-1:0] pin, input int ncyc);
      rst_n = 1'b0;
      button_pin = pin;
      model_reset();
      #1 check("reset_async");
      repeat (ncyc) begin
         @(posedge clk_1k);
         @(negedge clk_1k);
         check("reset_hold");
      end
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [N-1:0] rp;
      int rate;
      int snap_p [N], snap_r [N], snap_l [N];
      logic [N-1:0] mp, mr, ml;

      tbl[0] = '{4'b1111,   60, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
      tbl[1] = '{4'b0101,   60, 4'b0101, 4'b1010, 4'b0000, 4'b0000};
      tbl[2] = '{4'b1010,   60, 4'b1010, 4'b0101, 4'b1010, 4'b0000};
      tbl[3] = '{4'b0000,   30, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
      tbl[4] = '{4'b1010,   60, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
      tbl[5] = '{4'b1111,   60, 4'b1111, 4'b0000, 4'b0101, 4'b0000};
      tbl[6] = '{4'b1110, 1060, 4'b1110, 4'b0001, 4'b0000, 4'b0001};
      tbl[7] = '{4'b1111,   60, 4'b1111, 4'b0000, 4'b0001, 4'b0000};

      @(negedge clk_1k);

      // Reset with all pins held low, then simultaneous presses
      clear_log();
      do_reset(4'b0000, 3);
      for (int k = 0; k < 60; k++) step(4'b0000);
      for (int i = 0; i < N; i++) check_int($sformatf("reset_press_t_ch%0d", i), t_press[i], 51);
      for (int k = 0; k < 60; k++) step(4'b1111);

      // Bounce rejection on ch0
      clear_log();
      for (int k = 0; k < 200; k++) step({3'b111, (((k / 10) % 2) == 0) ? 1'b0 : 1'b1});
      for (int k = 0; k < 60; k++) step(4'b1111);
      check_int("bounce_press_cnt", cnt_press[0], 0);
      check_int("bounce_release_cnt", cnt_release[0], 0);

      // Clean press/release on ch1
      clear_log();
      t0 = cyc;
      for (int k = 0; k < 300; k++) step(4'b1101);
      for (int k = 0; k < 100; k++) step(4'b1111);
      check_int("clean_press_t", t_press[1] - t0, 51);
      check_int("clean_release_t", t_release[1] - t0, 351);
      check_int("clean_long_cnt", cnt_long[1], 0);

      // Long press on ch2
      clear_log();
      t0 = cyc;
      for (int k = 0; k < 1700; k++) step(4'b1011);
      for (int k = 0; k < 100; k++) step(4'b1111);
      check_int("long_press_t", t_press[2] - t0, 51);
      check_int("long_long_t", t_long[2] - t0, 1051);
      check_int("long_release_cnt", cnt_release[2], 1);
      check_int("long_release_t", t_release[2] - t0, 1751);
`ifdef BUTTON_ARRAY_REPEAT_EN
      check_int("long_rep_cnt", rep_q.size(), 3);
      for (int k = 0; k < 3; k++)
         check_int($sformatf("long_rep%0d_t", k), (k < rep_q.size()) ? rep_q[k] - t0 : -1, 1251 + RMS * k);
`else
      check_int("long_rep_cnt", rep_q.size(), 0);
`endif

      // Reset while ch3 is in the long-hold state
      clear_log();
      t0 = cyc;
      for (int k = 0; k < 1100; k++) step(4'b0111);
      check_int("midrst_long_t", t_long[3] - t0, 1051);
      do_reset(4'b0111, 1);
      for (int k = 0; k < 60; k++) step(4'b0111);
      check_int("midrst_release_cnt", cnt_release[3], 0);
      check_int("midrst_repress_t", t_press[3], 51);
      for (int k = 0; k < 60; k++) step(4'b1111);

      // Phase table
      clear_log();
      do_reset(4'b1111, 2);
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            snap_p[i] = cnt_press[i]; snap_r[i] = cnt_release[i]; snap_l[i] = cnt_long[i];
         end
         for (int k = 0; k < tbl[r].len; k++) step(tbl[r].pin);
         for (int i = 0; i < N; i++) begin
            mp[i] = cnt_press[i] > snap_p[i];
            mr[i] = cnt_release[i] > snap_r[i];
            ml[i] = cnt_long[i] > snap_l[i];
         end
         check_int($sformatf("tbl%0d_level", r), int'(level_n), int'(tbl[r].lvl));
         check_int($sformatf("tbl%0d_press", r), int'(mp), int'(tbl[r].prs));
         check_int($sformatf("tbl%0d_release", r), int'(mr), int'(tbl[r].rel));
         check_int($sformatf("tbl%0d_long", r), int'(ml), int'(tbl[r].lng));
      end

      // Randomized activity with varying toggle rates against the model
      do_reset(4'b1111, 2);
      rp = '1;
      for (int b = 0; b < 40; b++) begin
         case ($urandom_range(0, 3))
            0:       rate = 6;
            1:       rate = 60;
            2:       rate = 400;
            default: rate = 1500;
         endcase
         if (b == 20) do_reset(rp, 1);
         for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, rate - 1) == 0) rp[i] = ~rp[i];
            step(rp);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
